tank_key_ctrl: RTL
==================

Name: tank_key_ctrl

Overview:
- Consumes decoded PS/2 key events (10-bit {expand, break, code} word plus 1-cycle ready strobe from the keyboard decoder) and maintains a held-key bitmap for two players.
- Schedules per-tank commands: registered direction/move per player and rate-limited fire pulses aligned to the game tick.
- Sits between the PS/2 decoder and the tank motion/bullet logic. It is the only consumer of keyboard events in the game core.

Parameters:
- COOLDOWN_TICKS, 15, number of game ticks after a fire pulse during which that player cannot fire again.
- CNT_W, 4, cooldown counter width. COOLDOWN_TICKS must be no greater than 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_code  in  10  {expand, break, scancode[7:0]} from the decoder
- key_valid  in  1  1-cycle strobe; key_code is valid in that cycle
- tick  in  1  1-cycle game-tick strobe (frame rate)
- game_run  in  1  1 = gameplay active
- p1_dir  out  2  P1 direction: 00 up, 01 down, 10 left, 11 right
- p1_move  out  1  P1 has any direction key held
- p1_fire  out  1  1-cycle fire pulse, only ever in a tick cycle
- p2_dir, p2_move, p2_fire  out  2/1/1  same as P1, for P2
- keys_held  out  10  bitmap [4:0] = P1 W,S,A,D,J; [9:5] = P2 Up,Down,Left,Right,Enter

Behaviour:
- Key map:
  - P1 uses non-extended codes: W=1D, S=1B, A=1C, D=23, fire J=3B.
  - P2 uses extended codes (expand=1): Up=75, Down=72, Left=6B, Right=74.
  - P2 fire is Enter, 5A with expand=0. Keypad Enter (E0 5A) is ignored.
  - Any other code, or a matching code with the wrong expand bit, is ignored with no state change.
- Event handling, in the key_valid cycle:
  - break=0 (make) sets the keys_held bit; break=1 clears it.
  - Typematic repeat makes on an already-held key leave the bitmap unchanged.
  - keys_held is registered and updates one cycle after key_valid.
- Direction scheduling, per player:
  - On a make of a direction key not previously held, last_dir takes that key.
  - On a break of the key equal to last_dir, last_dir falls back to the highest-priority key still held (up>down>left>right). If none is held, last_dir keeps its value.
  - Breaks of other keys do not change last_dir.
  - pN_dir = last_dir; pN_move = (any direction held) & game_run.
  - Both outputs are registered, valid one cycle after key_valid.
- Fire scheduling, per player:
  - A make of the fire key while not previously held sets pending.
  - On a tick with game_run=1, pending=1 and cooldown=0: pN_fire=1 for that cycle, pending cleared, cooldown loaded with COOLDOWN_TICKS.
  - Otherwise, on a tick with cooldown≠0: cooldown decrements by 1.
  - Result: with COOLDOWN_TICKS=3, a fire at tick n allows the next fire at tick n+4 at the earliest.
  - The fire decision uses pending as registered before the current cycle. A make arriving in a tick cycle is served at the next eligible tick.
  - A press during cooldown stays pending (at most one queued).
- game_run=0:
  - p*_move forced 0, fire pulses suppressed, pending cleared.
  - keys_held, last_dir and cooldown countdown continue as normal.
- P1 and P2 are fully independent. Simultaneous fires in the same tick are allowed.
- Reset (asynchronous, rst_n=0, valid even mid-operation):
  - keys_held=0, p*_dir=00, p*_move=0, p*_fire=0, pending=0, cooldown=0.
  - The first event after reset release is processed normally.

Optional Feature:
- TANK_AUTOFIRE_EN defined: while a fire key remains held, pending is re-armed on every tick at which cooldown=0 and no fire was issued, so a held key fires every COOLDOWN_TICKS+1 ticks.
- TANK_AUTOFIRE_EN undefined: exactly one fire per press; repeat makes are ignored.

Test Plan:
- Reset, then make 1D -> one cycle later keys_held[0]=1, p1_dir=00, p1_move=1. Break 1D -> p1_move=0, p1_dir stays 00.
- Make 1C, make 23, break 23 -> p1_dir goes 10, then 11, then back to 10 (A still held). p2 outputs unchanged throughout.
- Make E0-flagged 75 (key_code=10'h275) -> p2_dir=00, p2_move=1. key_code=10'h05A -> keys_held[9]=1. key_code=10'h25A -> ignored.
- COOLDOWN_TICKS=3, game_run=1: press/release J before tick 0, press again before tick 1 -> p1_fire at tick 0 and tick 4 only. Make J in the same cycle as tick 5 is served at the next eligible tick.
- Press J with game_run=0 -> no fire. Raise game_run -> still no fire (pending cleared). Assert rst_n=0 mid-cooldown -> all outputs 0; a fresh press fires at the first tick after reset.
- TANK_AUTOFIRE_EN defined: hold J for 10 ticks, COOLDOWN_TICKS=3 -> fires at ticks 0, 4, 8. Undefined: fire at tick 0 only.

Source files
------------

// File: rtl/tank_key_ctrl.sv
// Keyboard-to-tank command scheduler: held-key bitmap, per-player direction and rate-limited fire.
// Optional build macro TANK_AUTOFIRE_EN re-arms fire while the fire key stays held.
module tank_key_ctrl #(
    parameter int unsigned COOLDOWN_TICKS = 15,
    parameter int unsigned CNT_W          = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] key_code,
    input  logic       key_valid,
    input  logic       tick,
    input  logic       game_run,
    output logic [1:0] p1_dir,
    output logic       p1_move,
    output logic       p1_fire,
    output logic [1:0] p2_dir,
    output logic       p2_move,
    output logic       p2_fire,
    output logic [9:0] keys_held
);

    localparam logic [CNT_W-1:0] CoolLoad = CNT_W'(COOLDOWN_TICKS);

    logic [9:0]            held_q, held_d;
    logic [9:0]            hit;
    logic [9:0]            make_new;
    logic                  is_break;

    logic [1:0][1:0]       dir_q, dir_d;
    logic [1:0]            move_q, move_d;
    logic [1:0]            pend_q, pend_d;
    logic [1:0][CNT_W-1:0] cd_q, cd_d;
    logic [1:0]            fire;
    logic [1:0][3:0]       dir_held, dir_hit;
    logic [1:0]            last_broken;

    // Lowest set bit wins: up > down > left > right.
    function automatic logic [1:0] first_set(input logic [3:0] v);
        logic [1:0] idx;
        if (v[0])      idx = 2'd0;
        else if (v[1]) idx = 2'd1;
        else if (v[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

    assign is_break = key_code[8];

    always_comb begin
        hit = '0;
        if (key_valid) begin
            case ({key_code[9], key_code[7:0]})
                9'h01D:  hit[0] = 1'b1;
                9'h01B:  hit[1] = 1'b1;
                9'h01C:  hit[2] = 1'b1;
                9'h023:  hit[3] = 1'b1;
                9'h03B:  hit[4] = 1'b1;
                9'h175:  hit[5] = 1'b1;
                9'h172:  hit[6] = 1'b1;
                9'h16B:  hit[7] = 1'b1;
                9'h174:  hit[8] = 1'b1;
                9'h05A:  hit[9] = 1'b1;
                default: ;
            endcase
        end
    end

    assign held_d   = is_break ? (held_q & ~hit) : (held_q | hit);
    // Typematic repeats of a held key are not new presses.
    assign make_new = hit & ~held_q & {10{~is_break}};

    always_comb begin
        dir_d       = dir_q;
        move_d      = '0;
        pend_d      = '0;
        cd_d        = cd_q;
        fire        = '0;
        dir_held    = '0;
        dir_hit     = '0;
        last_broken = '0;
        for (int p = 0; p < 2; p++) begin
            dir_held[p]    = held_d[p*5 +: 4];
            dir_hit[p]     = hit[p*5 +: 4];
            last_broken[p] = is_break & dir_hit[p][dir_q[p]];

            if (|make_new[p*5 +: 4]) begin
                dir_d[p] = first_set(make_new[p*5 +: 4]);
            end else if (last_broken[p] && (|dir_held[p])) begin
                dir_d[p] = first_set(dir_held[p]);
            end
            move_d[p] = (|dir_held[p]) & game_run;

            fire[p] = tick & game_run & pend_q[p] & (cd_q[p] == '0);
            if (fire[p]) begin
                cd_d[p] = CoolLoad;
            end else if (tick && (cd_q[p] != '0)) begin
                cd_d[p] = cd_q[p] - CNT_W'(1);
            end

            pend_d[p] = (pend_q[p] & ~fire[p]) | make_new[p*5+4];
`ifdef TANK_AUTOFIRE_EN
            // Re-arm on the tick the cooldown expires so a held key fires every COOLDOWN_TICKS+1.
            if (tick && held_q[p*5+4] && !fire[p] && (cd_d[p] == '0)) begin
                pend_d[p] = 1'b1;
            end
`endif
            if (!game_run) begin
                pend_d[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= '0;
            dir_q  <= '0;
            move_q <= '0;
            pend_q <= '0;
            cd_q   <= '0;
        end else begin
            held_q <= held_d;
            dir_q  <= dir_d;
            move_q <= move_d;
            pend_q <= pend_d;
            cd_q   <= cd_d;
        end
    end

    assign keys_held = held_q;
    assign p1_dir    = dir_q[0];
    assign p1_move   = move_q[0];
    assign p1_fire   = fire[0];
    assign p2_dir    = dir_q[1];
    assign p2_move   = move_q[1];
    assign p2_fire   = fire[1];

endmodule
